// File: rtl/if_stage_if.sv
// if_stage_if: bundles the fetch-stage signals between the IF stage and its
// surroundings (hazard unit, EX redirect, instruction memory, ID stage).
//   stall, redirect_valid, redirect_pc : control into the stage
//   inst_addr / inst                   : async-read instruction memory port
//   if_id_*                            : IF/ID pipeline register contents
// Modports: master = the IF stage itself, slave = everything around it.
interface if_stage_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        if_id_valid;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_fault;

  modport master (
    input  stall, redirect_valid, redirect_pc, inst,
    output inst_addr, if_id_valid, if_id_inst, if_id_pc, if_id_pc_plus4, if_id_fault
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, inst,
    input  inst_addr, if_id_valid, if_id_inst, if_id_pc, if_id_pc_plus4, if_id_fault
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: RV32I instruction-fetch stage. Owns the PC, presents it to an
// asynchronous-read instruction memory and registers the returned word into
// IF/ID. Redirect (taken branch/jump from EX) beats stall beats advance.
// One BOOT cycle after reset release performs no capture.
// Ports:
//   clk, rst_n       : clock (rising edge), async active-low reset
//   bus (master)     : stall/redirect in, inst_addr/inst memory port, if_id_* out
//   perf_fetch_cnt   : advance count   (only with IF_PERF_CNT_EN defined)
//   perf_stall_cnt   : stall-edge count (only with IF_PERF_CNT_EN defined)
// Optional feature macro: IF_PERF_CNT_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  if_stage_if.master  bus
);

  typedef enum logic {BOOT, RUN} state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        fault;
  } ifid_t;

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);
  localparam ifid_t IFID_RST = '{valid: 1'b0, inst: NOP_INST, pc: 32'd0,
                                 pc4: 32'd0, fault: 1'b0};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  logic [31:0] pc_plus4;
  logic        in_range;

  assign pc_plus4 = pc_q + 32'd4;  // natural 2^32 wrap
  assign in_range = {2'b00, pc_q[31:2]} < IMEM_LIMIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      ifid_q  <= IFID_RST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    unique case (state_q)
      BOOT: state_d = RUN;  // inputs ignored, nothing captured
      RUN: begin
        if (bus.redirect_valid) begin
          // Flush: the word at inst_addr belongs to the wrong path.
          // if_id_pc/pc4 are left alone; valid=0 marks them meaningless.
          pc_d         = {bus.redirect_pc[31:2], 2'b00};
          ifid_d.valid = 1'b0;
          ifid_d.inst  = NOP_INST;
          ifid_d.fault = 1'b0;
        end else if (!bus.stall) begin
          pc_d         = pc_plus4;
          ifid_d.valid = 1'b1;
          ifid_d.pc    = pc_q;
          ifid_d.pc4   = pc_plus4;
          ifid_d.inst  = in_range ? bus.inst : NOP_INST;
          ifid_d.fault = !in_range;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign bus.inst_addr      = pc_q;
  assign bus.if_id_valid    = ifid_q.valid;
  assign bus.if_id_inst     = ifid_q.inst;
  assign bus.if_id_pc       = ifid_q.pc;
  assign bus.if_id_pc_plus4 = ifid_q.pc4;
  assign bus.if_id_fault    = ifid_q.fault;

`ifdef IF_PERF_CNT_EN
  logic run_adv, run_stall;
  assign run_adv   = (state_q == RUN) && !bus.redirect_valid && !bus.stall;
  assign run_stall = (state_q == RUN) && !bus.redirect_valid &&  bus.stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (run_adv)   perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (run_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed table-driven bench for if_stage. Models a 256-word
// async instruction memory; out-of-range reads return garbage that the stage
// must replace with the NOP. Rows are applied one clock edge each.
module tb_if_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_stage_if bus ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  if_stage #(.RESET_PC(32'h0), .IMEM_WORDS(256), .NOP_INST(32'h0000_0013)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .bus(bus.master)
  );

  logic [31:0] mem [256];
  assign bus.inst = (bus.inst_addr[31:10] == 22'd0) ? mem[bus.inst_addr[9:2]]
                                                    : 32'hDEAD_BEEF;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        fault;
    logic [31:0] addr;
  } vec_t;

  localparam logic [31:0] NOP = 32'h0000_0013;
  vec_t tbl [19];

  task automatic check_all(input int row, input logic v, input logic [31:0] i,
                           input logic [31:0] p, input logic [31:0] p4,
                           input logic f, input logic [31:0] a);
    check("valid", row, {31'd0, bus.if_id_valid}, {31'd0, v});
    check("inst",  row, bus.if_id_inst, i);
    check("pc",    row, bus.if_id_pc, p);
    check("pc4",   row, bus.if_id_pc_plus4, p4);
    check("fault", row, {31'd0, bus.if_id_fault}, {31'd0, f});
    check("addr",  row, bus.inst_addr, a);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0A00_0000 | 32'(i);
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;

    //           st  rv  rpc           valid inst          pc            pc4           f  addr
    tbl[0]  = '{1, 1, 32'h80,        0, NOP,          32'h0,        32'h0,        0, 32'h0};  // BOOT ignores inputs
    tbl[1]  = '{0, 0, 32'h0,         1, 32'h00500093, 32'h0,        32'h4,        0, 32'h4};
    tbl[2]  = '{0, 0, 32'h0,         1, 32'h00A00113, 32'h4,        32'h8,        0, 32'h8};
    tbl[3]  = '{1, 0, 32'h0,         1, 32'h00A00113, 32'h4,        32'h8,        0, 32'h8};
    tbl[4]  = '{1, 0, 32'h0,         1, 32'h00A00113, 32'h4,        32'h8,        0, 32'h8};
    tbl[5]  = '{1, 0, 32'h0,         1, 32'h00A00113, 32'h4,        32'h8,        0, 32'h8};
    tbl[6]  = '{0, 0, 32'h0,         1, 32'h0A000002, 32'h8,        32'hC,        0, 32'hC};
    tbl[7]  = '{1, 1, 32'h40,        0, NOP,          32'h8,        32'hC,        0, 32'h40};
    tbl[8]  = '{0, 0, 32'h0,         1, 32'h0A000010, 32'h40,       32'h44,       0, 32'h44};
    tbl[9]  = '{0, 1, 32'h23,        0, NOP,          32'h40,       32'h44,       0, 32'h20};
    tbl[10] = '{0, 0, 32'h0,         1, 32'h0A000008, 32'h20,       32'h24,       0, 32'h24};
    tbl[11] = '{0, 1, 32'h400,       0, NOP,          32'h20,       32'h24,       0, 32'h400};
    tbl[12] = '{0, 0, 32'h0,         1, NOP,          32'h400,      32'h404,      1, 32'h404};
    tbl[13] = '{1, 0, 32'h0,         1, NOP,          32'h400,      32'h404,      1, 32'h404};
    tbl[14] = '{0, 1, 32'h3FC,       0, NOP,          32'h400,      32'h404,      0, 32'h3FC};
    tbl[15] = '{0, 0, 32'h0,         1, 32'h0A0000FF, 32'h3FC,      32'h400,      0, 32'h400};
    tbl[16] = '{0, 1, 32'hFFFFFFFC,  0, NOP,          32'h3FC,      32'h400,      0, 32'hFFFFFFFC};
    tbl[17] = '{0, 0, 32'h0,         1, NOP,          32'hFFFFFFFC, 32'h0,        1, 32'h0};
    tbl[18] = '{0, 0, 32'h0,         1, 32'h00500093, 32'h0,        32'h4,        0, 32'h4};

    bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all(-1, 0, NOP, 0, 0, 0, 0);
`ifdef IF_PERF_CNT_EN
    check("perf_fetch_rst", -1, perf_fetch_cnt, 0);
    check("perf_stall_rst", -1, perf_stall_cnt, 0);
`endif
    rst_n = 1;

    for (int r = 0; r < 19; r++) begin
      bus.stall = tbl[r].stall;
      bus.redirect_valid = tbl[r].rv;
      bus.redirect_pc = tbl[r].rpc;
      @(posedge clk);
      #1;
      check_all(r, tbl[r].valid, tbl[r].inst, tbl[r].pc, tbl[r].pc4,
                tbl[r].fault, tbl[r].addr);
    end
`ifdef IF_PERF_CNT_EN
    check("perf_fetch_tbl", 19, perf_fetch_cnt, 9);
    check("perf_stall_tbl", 19, perf_stall_cnt, 4);
`endif

    // Async reset mid-run while stalled, between clock edges
    bus.stall = 1; bus.redirect_valid = 0;
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    check("arst_valid", 100, {31'd0, bus.if_id_valid}, 0);
    check("arst_addr",  100, bus.inst_addr, 0);
    check("arst_inst",  100, bus.if_id_inst, NOP);
    check("arst_pc4",   100, bus.if_id_pc_plus4, 0);
`ifdef IF_PERF_CNT_EN
    check("arst_perf", 100, perf_fetch_cnt, 0);
`endif

    // Reboot: BOOT edge, 5 advances, 2 stalls
    @(negedge clk);
    rst_n = 1;
    bus.stall = 0;
    @(posedge clk); #1;
    check("boot_valid", 101, {31'd0, bus.if_id_valid}, 0);
    repeat (5) @(posedge clk);
    #1;
    bus.stall = 1;
    repeat (2) @(posedge clk);
    #1;
    bus.stall = 0;
    check("seq_pc",   102, bus.if_id_pc, 32'h10);
    check("seq_addr", 102, bus.inst_addr, 32'h14);
    check("seq_inst", 102, bus.if_id_inst, 32'h0A000004);
`ifdef IF_PERF_CNT_EN
    check("perf_fetch", 102, perf_fetch_cnt, 5);
    check("perf_stall", 102, perf_stall_cnt, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
